// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int START_TO = 64,
  parameter int GAP_CYC  = 16
) (
  input  logic                 clk_uart,
  input  logic                 clrn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           d_in,
  output logic                 tx_send,
  input  logic                 sending,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 tx_err
);
  localparam int TMAX = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_S, WAIT_D, GAP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] rr_q, rr_d, grant_q, grant_d, win;
  logic [7:0] d_in_q, d_in_d;
  logic found;
  logic [7:0] req_x;
  logic [63:0] data_x;
  assign req_x = 8'(req);
  assign data_x = 64'(req_data);
  assign busy = state_q != IDLE;
  assign tx_send = state_q == START;
  assign ack = (state_q == LOAD) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign d_in = d_in_q;
  assign grant_id = grant_q;
  // pick the first asserted request at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    win = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_x[3'((int'(rr_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win = 3'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end
  // next state, shared timer and values latched at grant time
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rr_d = rr_q;
    grant_d = grant_q;
    d_in_d = d_in_q;
    tx_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sending && found) begin
          state_d = LOAD;
          grant_d = win;
          d_in_d = data_x[{win, 3'b000} +: 8];
          rr_d = (int'(win) == NUM_REQ - 1) ? 3'd0 : win + 3'd1;
        end
      end
      LOAD: state_d = START;
      START: begin
        state_d = WAIT_S;
        timer_d = '0;
      end
      WAIT_S: begin
        if (sending) begin
          state_d = WAIT_D;
        end else if (timer_q == START_LAST) begin
          tx_err = 1'b1;
          timer_d = '0;
          state_d = (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_D: begin
        if (!sending) begin
          timer_d = '0;
          state_d = (GAP_CYC > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) state_d = IDLE;
        else timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and data registers; reset aborts any frame in progress
  always_ff @(posedge clk_uart or posedge clrn) begin
    if (clrn) begin
      state_q <= IDLE;
      timer_q <= '0;
      rr_q <= '0;
      grant_q <= '0;
      d_in_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      d_in_q <= d_in_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table, corner sequences and randomized traffic against a transaction model
module tb_uart_tx_arbiter;
  localparam int NUM = 4;
  localparam int START_TO = 64;
  localparam int GAP = 16;
  logic clk_uart, clrn, sending, tx_send, busy, tx_err;
  logic [NUM-1:0] req, ack;
  logic [8*NUM-1:0] req_data;
  logic [7:0] d_in;
  logic [2:0] grant_id;
  int cyc, n_chk, n_fail;
  typedef struct {
    logic [3:0] req;
    logic [7:0] base;
    int gnt;
    int len;
  } vec_t;
  vec_t tbl [10];
  int ptr, free_at, ack_cyc, win, rise_c, fall_c, err_c;
  logic [7:0] bytes [NUM];
  logic [3:0] pend;
  bit in_txn;

  uart_tx_arbiter #(.NUM_REQ(NUM), .START_TO(START_TO), .GAP_CYC(GAP)) dut (
    .clk_uart(clk_uart), .clrn(clrn), .req(req), .req_data(req_data), .ack(ack),
    .d_in(d_in), .tx_send(tx_send), .sending(sending), .busy(busy),
    .grant_id(grant_id), .tx_err(tx_err)
  );

  initial clk_uart = 1'b0;
  always #5 clk_uart = ~clk_uart;

  task automatic tick();
    @(posedge clk_uart);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < NUM; i++) req_data[8*i +: 8] = base ^ 8'(i);
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    req = '0;
    sending = 1'b0;
    tick();
    tick();
    clrn = 1'b0;
  endtask

  // one complete frame starting in IDLE; leaves the DUT back in IDLE
  task automatic run_txn(input logic [3:0] req_m, input logic [7:0] base, input int g, input int len);
    int acks, sends;
    acks = 0;
    sends = 0;
    req = req_m;
    set_data(base);
    tick();
    chk("ack", ack, 32'(4'b0001 << g));
    chk("d_in", d_in, base ^ 8'(g));
    chk("grant_id", grant_id, g);
    chk("tx_send_early", tx_send, 0);
    req = req_m & ~(4'b0001 << g);
    tick();
    chk("tx_send", tx_send, 1);
    chk("ack_width", ack, 0);
    tick();
    sending = 1'b1;
    repeat (len) begin
      tick();
      if (|ack) acks++;
      if (tx_send) sends++;
    end
    sending = 1'b0;
    repeat (GAP) begin
      tick();
      if (|ack) acks++;
      if (tx_send) sends++;
    end
    chk("busy_in_gap", busy, 1);
    tick();
    chk("busy_after_gap", busy, 0);
    chk("extra_pulses", acks + sends, 0);
    chk("d_in_hold", d_in, base ^ 8'(g));
  endtask

  initial begin
    int gorder [5];
    int s, e, cnt;
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    req_data = '0;
    gorder = '{0, 1, 2, 3, 0};
    tbl = '{'{4'b0001, 8'hA5, 0, 160}, '{4'b0001, 8'h11, 0, 4}, '{4'b1001, 8'h22, 3, 4},
            '{4'b0110, 8'h33, 1, 5},   '{4'b0011, 8'h44, 0, 3}, '{4'b0010, 8'h55, 1, 2},
            '{4'b1100, 8'h66, 2, 6},   '{4'b1111, 8'h77, 3, 1}, '{4'b1110, 8'h88, 1, 7},
            '{4'b1000, 8'h99, 3, 2}};
    // reset values
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_d_in", d_in, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tx_err", tx_err, 0);
    // all requesters persistently asking: strict rotation
    for (int i = 0; i < 5; i++) run_txn(4'hF, 8'h10 * 8'(i + 1), gorder[i], 3);
    // directed table, starting from a fresh pointer
    do_reset();
    for (int i = 0; i < 10; i++) run_txn(tbl[i].req, tbl[i].base, tbl[i].gnt, tbl[i].len);
    // request rising while a frame is on the wire waits for GAP and IDLE
    req = 4'b0001;
    set_data(8'hC0);
    tick();
    chk("seqb_ack0", ack, 4'b0001);
    req = '0;
    tick();
    tick();
    sending = 1'b1;
    repeat (3) tick();
    req = 4'b1000;
    req_data[31:24] = 8'h3C;
    cnt = 0;
    repeat (10) begin
      tick();
      if (|ack) cnt++;
    end
    sending = 1'b0;
    repeat (GAP + 1) begin
      tick();
      if (|ack) cnt++;
    end
    chk("seqb_no_preempt", cnt, 0);
    tick();
    chk("seqb_ack3", ack, 4'b1000);
    chk("seqb_d_in", d_in, 8'h3C);
    // transmitter never starts: timeout, gap, then normal service
    req = '0;
    tick();
    chk("stuck_tx_send", tx_send, 1);
    s = cyc;
    e = -1;
    for (int k = 0; k < START_TO + 8 && e < 0; k++) begin
      tick();
      if (tx_err) e = cyc;
    end
    chk("tx_err_delay", e - s, START_TO);
    tick();
    chk("tx_err_width", tx_err, 0);
    repeat (GAP - 1) tick();
    chk("err_gap_busy", busy, 1);
    tick();
    chk("err_gap_idle", busy, 0);
    run_txn(4'b0100, 8'h5A, 2, 5);
    // asynchronous reset in the middle of a frame
    req = 4'b0010;
    set_data(8'hE0);
    tick();
    req = '0;
    tick();
    tick();
    sending = 1'b1;
    tick();
    tick();
    #2;
    clrn = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_d_in", d_in, 0);
    chk("async_grant", grant_id, 0);
    chk("async_ack", ack, 0);
    chk("async_tx_send", tx_send, 0);
    req = 4'b1001;
    set_data(8'h90);
    tick();
    tick();
    clrn = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (|ack || tx_send) cnt++;
    end
    chk("post_rst_wait", cnt, 0);
    sending = 1'b0;
    tick();
    chk("post_rst_ack", ack, 4'b0001);
    chk("post_rst_grant", grant_id, 0);
    // external activity in IDLE blocks the grant
    do_reset();
    sending = 1'b1;
    req = 4'b0100;
    set_data(8'h21);
    cnt = 0;
    repeat (8) begin
      tick();
      if (|ack) cnt++;
    end
    chk("idle_sending_block", cnt, 0);
    sending = 1'b0;
    tick();
    chk("idle_release_ack", ack, 4'b0100);
    chk("idle_release_d_in", d_in, 8'h23);
    // randomized traffic against a transaction-level model
    do_reset();
    ptr = 0;
    free_at = cyc;
    ack_cyc = -10;
    err_c = -10;
    rise_c = 0;
    fall_c = 0;
    in_txn = 0;
    pend = '0;
    win = 0;
    for (int it = 0; it < 4000; it++) begin
      tick();
      if (cyc == ack_cyc + 1) pend[win] = 1'b0;
      for (int i = 0; i < NUM; i++)
        if (!pend[i] && !(cyc == ack_cyc + 1 && i == win) && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          bytes[i] = 8'($urandom);
        end
      req = pend;
      for (int i = 0; i < NUM; i++) req_data[8*i +: 8] = bytes[i];
      sending = (cyc >= rise_c && cyc < fall_c);
      #1;
      chk("rnd_ack", ack, (cyc == ack_cyc) ? 32'(4'b0001 << win) : 0);
      chk("rnd_tx_send", tx_send, 32'(cyc == ack_cyc + 1));
      chk("rnd_tx_err", tx_err, 32'(cyc == err_c));
      chk("rnd_busy", busy, 32'(!(cyc >= free_at && !in_txn)));
      if (cyc == ack_cyc) begin
        chk("rnd_d_in", d_in, bytes[win]);
        chk("rnd_grant", grant_id, win);
      end
      if (!in_txn && cyc >= free_at && !sending && pend != 0) begin
        for (int k = NUM - 1; k >= 0; k--)
          if (pend[(ptr + k) % NUM]) win = (ptr + k) % NUM;
        ack_cyc = cyc + 1;
        ptr = (win + 1) % NUM;
        in_txn = 1;
      end else if (in_txn && cyc == ack_cyc + 1) begin
        if ($urandom_range(0, 9) == 0) begin
          err_c = cyc + START_TO;
          free_at = err_c + GAP + 1;
        end else begin
          rise_c = cyc + int'($urandom_range(1, 3));
          fall_c = rise_c + int'($urandom_range(1, 12));
          free_at = fall_c + GAP + 1;
        end
        in_txn = 0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
